uart_alu_sequencer: RTL and testbench
=====================================

Name: uart_alu_sequencer

Overview:
- Controller between the UART receiver/transmitter and the ALU.
- Collects three received bytes in order (operand A, operand B, opcode) and drives them to the ALU.
- After a fixed settle delay, captures the ALU result and hands it to the UART transmitter with a start/done handshake.
- Single frame in flight; a new frame is accepted only after the result has been sent.

Parameters:
- DATA_W, 8, width of operands, opcode, result and UART byte.
- ALU_LAT, 1, cycles from operands/opcode stable to result capture (1..15).
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles; used only with RX_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- i_rx_data  input  DATA_W  byte from UART receiver; valid when i_rx_done=1.
- i_rx_done  input  1  one-cycle pulse, new received byte.
- i_alu_result  input  DATA_W  combinational ALU output.
- i_tx_done  input  1  one-cycle pulse, transmitter finished the byte.
- o_datoA  output  DATA_W  ALU operand A (registered).
- o_datoB  output  DATA_W  ALU operand B (registered).
- o_opcode  output  DATA_W  ALU opcode (registered).
- o_tx_data  output  DATA_W  byte to transmit (registered captured result).
- o_tx_start  output  1  one-cycle pulse requesting transmission of o_tx_data.
- o_busy  output  1  high in EXEC, SEND, WAIT_TX.
- o_drop  output  1  one-cycle pulse: received byte discarded.
- o_error  output  1  one-cycle pulse: frame aborted by timeout (tied 0 without RX_TIMEOUT_EN).

Behaviour:
- Reset (reset=0, asynchronous):
  - State WAIT_A.
  - o_datoA, o_datoB, o_opcode, o_tx_data = 0.
  - o_tx_start, o_busy, o_drop, o_error = 0.
  - Settle counter and timeout counter cleared.
  - Reset mid-frame discards the partial frame.
  - Reset in WAIT_TX does not re-send.
- States:
  - WAIT_A: on i_rx_done, o_datoA <= i_rx_data, go to WAIT_B.
  - WAIT_B: on i_rx_done, o_datoB <= i_rx_data, go to WAIT_OP.
  - WAIT_OP: on i_rx_done, o_opcode <= i_rx_data, load settle counter with ALU_LAT, go to EXEC.
  - EXEC: decrement the counter each cycle. On the cycle the counter reads 1, o_tx_data <= i_alu_result and go to SEND. With ALU_LAT=1, capture occurs the cycle after entering EXEC.
  - SEND: o_tx_start=1 for exactly this one cycle, then go to WAIT_TX.
  - WAIT_TX: hold o_tx_data; on i_tx_done go to WAIT_A.
- Operand registers keep their values until overwritten by the next frame, so the ALU inputs stay stable through SEND/WAIT_TX.
- Latency: from the opcode i_rx_done cycle to the o_tx_start pulse = ALU_LAT+1 cycles.
- i_rx_done in EXEC or SEND: byte discarded, o_drop pulses the next cycle, state unchanged.
- i_rx_done in WAIT_TX without i_tx_done: discarded, o_drop pulses.
- i_rx_done and i_tx_done in the same WAIT_TX cycle: byte accepted as operand A, go directly to WAIT_B, no o_drop.
- i_tx_done outside WAIT_TX: ignored.
- No arithmetic beyond the counters. Bytes are copied unmodified; the result is captured at full DATA_W, no truncation.

Optional Feature:
- Macro: RX_TIMEOUT_EN.
- Defined:
  - In WAIT_B and WAIT_OP, a counter increments every cycle and restarts at 0 on each accepted byte.
  - If it reaches TIMEOUT_CYCLES-1 without i_rx_done: return to WAIT_A, pulse o_error one cycle; operand registers are not cleared.
  - An i_rx_done arriving in the same cycle as the timeout wins: byte accepted, no error.
- Undefined: no counter logic, o_error tied 0, and WAIT_B/WAIT_OP wait indefinitely.

Test Plan:
- Normal frame, ALU_LAT=1: rx 0x05, 0x03, 0x20; model ALU returns A+B → o_datoA=0x05, o_datoB=0x03, o_opcode=0x20; o_tx_start pulses 2 cycles after the third rx_done with o_tx_data=0x08; after i_tx_done, state WAIT_A and o_busy=0.
- ALU_LAT=4: same frame with result 0xFF → o_tx_start 5 cycles after the opcode byte, o_tx_data=0xFF; exactly one start pulse.
- Extra byte while busy: rx 0x7E during WAIT_TX → o_drop pulses once; o_datoA unchanged; next frame proceeds normally.
- Simultaneous events: i_tx_done and i_rx_done(0x11) in the same cycle → o_datoA=0x11, state WAIT_B, o_drop=0.
- Reset mid-frame: after bytes 0x05, 0x03, assert reset → all outputs 0 immediately (asynchronously); after release, a full frame 0x02, 0x02, 0x20 yields 0x04.
- RX_TIMEOUT_EN, TIMEOUT_CYCLES=16: rx 0x05 then silence → o_error pulses 16 cycles later and the state returns to WAIT_A; with the macro undefined, the same stimulus leaves the block in WAIT_B with o_error=0.

Source files
------------

// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer: gathers operand A, operand B and opcode bytes from the
// UART receiver, presents them to the ALU, waits ALU_LAT cycles, captures the
// result and hands it to the UART transmitter with a start/done handshake.
// Only one frame is in flight at a time.
// Optional feature macro: RX_TIMEOUT_EN (inter-byte timeout in WAIT_B/WAIT_OP).
module uart_alu_sequencer #(
   parameter int DATA_W         = 8,
   parameter int ALU_LAT        = 1,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] i_rx_data,
   input  logic              i_rx_done,
   input  logic [DATA_W-1:0] i_alu_result,
   input  logic              i_tx_done,
   output logic [DATA_W-1:0] o_datoA,
   output logic [DATA_W-1:0] o_datoB,
   output logic [DATA_W-1:0] o_opcode,
   output logic [DATA_W-1:0] o_tx_data,
   output logic              o_tx_start,
   output logic              o_busy,
   output logic              o_drop,
   output logic              o_error
);

   typedef enum logic [2:0] {
      WAIT_A,
      WAIT_B,
      WAIT_OP,
      EXEC,
      SEND,
      WAIT_TX
   } state_t;

   // ALU_LAT is limited to 1..15, so four bits hold the settle count
   localparam int CNT_W = 4;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] settle_q;
   logic             load_a;
   logic             load_b;
   logic             load_op;
   logic             capture;
   logic             drop_d;
   logic             drop_q;
   logic             timeout_hit;

   // State register; reset abandons any partial frame or pending transmission
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= WAIT_A;
      else        state_q <= state_d;
   end

   // Next-state and datapath strobes; bytes arriving while busy are dropped
   always_comb begin
      state_d = state_q;
      load_a  = 1'b0;
      load_b  = 1'b0;
      load_op = 1'b0;
      capture = 1'b0;
      drop_d  = 1'b0;
      unique case (state_q)
         WAIT_A: begin
            if (i_rx_done) begin
               load_a  = 1'b1;
               state_d = WAIT_B;
            end
         end
         WAIT_B: begin
            if (i_rx_done) begin
               load_b  = 1'b1;
               state_d = WAIT_OP;
            end else if (timeout_hit) begin
               state_d = WAIT_A;
            end
         end
         WAIT_OP: begin
            if (i_rx_done) begin
               load_op = 1'b1;
               state_d = EXEC;
            end else if (timeout_hit) begin
               state_d = WAIT_A;
            end
         end
         EXEC: begin
            drop_d = i_rx_done;
            if (settle_q == CNT_W'(1)) begin
               capture = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            drop_d  = i_rx_done;
            state_d = WAIT_TX;
         end
         WAIT_TX: begin
            if (i_tx_done) begin
               state_d = WAIT_A;
               if (i_rx_done) begin
                  load_a  = 1'b1;
                  state_d = WAIT_B;
               end
            end else begin
               drop_d = i_rx_done;
            end
         end
         default: state_d = WAIT_A;
      endcase
   end

   // Operand, opcode and result registers hold until the next frame rewrites them
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_datoA   <= '0;
         o_datoB   <= '0;
         o_opcode  <= '0;
         o_tx_data <= '0;
      end else begin
         if (load_a)  o_datoA   <= i_rx_data;
         if (load_b)  o_datoB   <= i_rx_data;
         if (load_op) o_opcode  <= i_rx_data;
         if (capture) o_tx_data <= i_alu_result;
      end
   end

   // Settle counter: loaded with the ALU latency on the opcode byte, counts down in EXEC
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                 settle_q <= '0;
      else if (load_op)           settle_q <= CNT_W'(ALU_LAT);
      else if (state_q == EXEC)   settle_q <= settle_q - CNT_W'(1);
   end

   // Drop indication is registered so it appears the cycle after the discarded byte
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) drop_q <= 1'b0;
      else        drop_q <= drop_d;
   end

`ifdef RX_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TO_W-1:0] to_cnt_q;
   logic            in_rx_wait;
   logic            error_q;

   assign in_rx_wait  = (state_q == WAIT_B) || (state_q == WAIT_OP);
   assign timeout_hit = in_rx_wait && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   // Inter-byte timer: runs only while waiting for B or opcode, restarts on every accepted byte
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                        to_cnt_q <= '0;
      else if (!in_rx_wait || i_rx_done) to_cnt_q <= '0;
      else                               to_cnt_q <= to_cnt_q + TO_W'(1);
   end

   // Error pulse on an abort; a byte landing on the timeout cycle takes priority
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) error_q <= 1'b0;
      else        error_q <= timeout_hit && !i_rx_done;
   end

   assign o_error = error_q;
`else
   assign timeout_hit = 1'b0;
   assign o_error     = 1'b0;
`endif

   assign o_tx_start = (state_q == SEND);
   assign o_busy     = (state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_TX);
   assign o_drop     = drop_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Self-checking bench for uart_alu_sequencer. Two instances (ALU_LAT=1 and
// ALU_LAT=4) see identical UART traffic; expected results come from a
// frame-level reference model (byte triple -> ALU result, latency, drop count).
module tb_uart_alu_sequencer;

   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 16;

   logic              clk;
   logic              reset;
   logic [DATA_W-1:0] rx_data;
   logic              rx_done;
   logic              tx_done;

   logic [DATA_W-1:0] alu_res1, alu_res4;
   logic [DATA_W-1:0] dato_a1, dato_b1, opcode1, tx_data1;
   logic [DATA_W-1:0] dato_a4, dato_b4, opcode4, tx_data4;
   logic              tx_start1, busy1, drop1, error1;
   logic              tx_start4, busy4, drop4, error4;

   int tests_run = 0;
   int tests_failed = 0;

   // Stand-in ALU seen by both instances
   function automatic logic [DATA_W-1:0] aluFunc(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [DATA_W-1:0] op);
      case (op)
         8'h20:   return a + b;
         8'h22:   return a - b;
         8'h24:   return a & b;
         8'h25:   return a | b;
         8'h26:   return a ^ b;
         8'h27:   return ~(a | b);
         default: return a;
      endcase
   endfunction

   assign alu_res1 = aluFunc(dato_a1, dato_b1, opcode1);
   assign alu_res4 = aluFunc(dato_a4, dato_b4, opcode4);

   uart_alu_sequencer #(.DATA_W(DATA_W), .ALU_LAT(1), .TIMEOUT_CYCLES(TIMEOUT)) u_dut_lat1 (
      .clk(clk), .reset(reset),
      .i_rx_data(rx_data), .i_rx_done(rx_done),
      .i_alu_result(alu_res1), .i_tx_done(tx_done),
      .o_datoA(dato_a1), .o_datoB(dato_b1), .o_opcode(opcode1), .o_tx_data(tx_data1),
      .o_tx_start(tx_start1), .o_busy(busy1), .o_drop(drop1), .o_error(error1)
   );

   uart_alu_sequencer #(.DATA_W(DATA_W), .ALU_LAT(4), .TIMEOUT_CYCLES(TIMEOUT)) u_dut_lat4 (
      .clk(clk), .reset(reset),
      .i_rx_data(rx_data), .i_rx_done(rx_done),
      .i_alu_result(alu_res4), .i_tx_done(tx_done),
      .o_datoA(dato_a4), .o_datoB(dato_b4), .o_opcode(opcode4), .o_tx_data(tx_data4),
      .o_tx_start(tx_start4), .o_busy(busy4), .o_drop(drop4), .o_error(error4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sendByte(input logic [DATA_W-1:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_a1"}, dato_a1, 0);
      checkOutput({tag, "_b1"}, dato_b1, 0);
      checkOutput({tag, "_op1"}, opcode1, 0);
      checkOutput({tag, "_tx1"}, tx_data1, 0);
      checkOutput({tag, "_flags1"}, {tx_start1, busy1, drop1, error1}, 0);
      checkOutput({tag, "_a4"}, dato_a4, 0);
      checkOutput({tag, "_flags4"}, {tx_start4, busy4, drop4, error4}, 0);
   endtask

   // One frame: bytes in, result out, optional dropped bytes, optional chained next A
   task automatic applyStimulus(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                input logic [DATA_W-1:0] op, input bit a_already,
                                input int extras, input bit chain,
                                input logic [DATA_W-1:0] next_a);
      int lat1, lat4, starts1, starts4, drops1, drops4, injected, k;
      logic [DATA_W-1:0] exp_res;
      exp_res = aluFunc(a, b, op);
      lat1 = -1; lat4 = -1; starts1 = 0; starts4 = 0;
      drops1 = 0; drops4 = 0; injected = 0; k = 0;
      if (!a_already) sendByte(a);
      sendByte(b);
      sendByte(op);
      while ((starts1 == 0 || starts4 == 0) && k < 40) begin
         if (injected < extras && $urandom_range(0, 2) == 0) begin
            rx_data = DATA_W'($urandom);
            rx_done = 1'b1;
            injected++;
         end
         if (k == 0) tx_done = 1'b1;
         tick();
         rx_done = 1'b0;
         tx_done = 1'b0;
         k++;
         if (tx_start1) begin starts1++; if (lat1 < 0) lat1 = k + 1; end
         if (tx_start4) begin starts4++; if (lat4 < 0) lat4 = k + 1; end
         drops1 += int'(drop1);
         drops4 += int'(drop4);
      end
      for (int i = 0; i < 3; i++) begin
         if (injected < extras) begin
            rx_data = DATA_W'($urandom);
            rx_done = 1'b1;
            injected++;
         end
         tick();
         rx_done = 1'b0;
         starts1 += int'(tx_start1);
         starts4 += int'(tx_start4);
         drops1 += int'(drop1);
         drops4 += int'(drop4);
      end
      checkOutput("frame_a1", dato_a1, a);
      checkOutput("frame_b1", dato_b1, b);
      checkOutput("frame_op1", opcode1, op);
      checkOutput("result1", tx_data1, exp_res);
      checkOutput("latency1", lat1, 2);
      checkOutput("starts1", starts1, 1);
      checkOutput("busy_tx1", busy1, 1);
      checkOutput("frame_a4", dato_a4, a);
      checkOutput("frame_op4", opcode4, op);
      checkOutput("result4", tx_data4, exp_res);
      checkOutput("latency4", lat4, 5);
      checkOutput("starts4", starts4, 1);
      checkOutput("busy_tx4", busy4, 1);
      tx_done = 1'b1;
      if (chain) begin
         rx_data = next_a;
         rx_done = 1'b1;
      end
      tick();
      tx_done = 1'b0;
      rx_done = 1'b0;
      drops1 += int'(drop1);
      drops4 += int'(drop4);
      checkOutput("drops1", drops1, extras);
      checkOutput("drops4", drops4, extras);
      checkOutput("idle_busy1", busy1, 0);
      checkOutput("idle_busy4", busy4, 0);
      checkOutput("next_a1", dato_a1, chain ? next_a : a);
      checkOutput("next_a4", dato_a4, chain ? next_a : a);
   endtask

   initial begin
      int k;
      int errs;
      logic [DATA_W-1:0] ops [6];
      logic [DATA_W-1:0] a, b, op, na;
      bit pending, chain;
      ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'h24;
      ops[3] = 8'h25; ops[4] = 8'h26; ops[5] = 8'h27;

      reset = 1'b0;
      rx_data = '0;
      rx_done = 1'b0;
      tx_done = 1'b0;
      #1;
      checkAllZero("reset");
      repeat (2) tick();
      reset = 1'b1;

      $display("[TB] stray tx_done while idle");
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      checkOutput("stray_txdone_busy", busy1, 0);

      $display("[TB] directed frames");
      applyStimulus(8'h05, 8'h03, 8'h20, 1'b0, 0, 1'b0, 8'h00);
      applyStimulus(8'hF0, 8'h0F, 8'h20, 1'b0, 0, 1'b0, 8'h00);
      applyStimulus(8'h12, 8'h34, 8'h26, 1'b0, 1, 1'b0, 8'h00);
      applyStimulus(8'h40, 8'h01, 8'h22, 1'b0, 0, 1'b1, 8'h11);
      applyStimulus(8'h11, 8'h22, 8'h25, 1'b1, 0, 1'b0, 8'h00);

      $display("[TB] reset mid-frame");
      sendByte(8'h05);
      sendByte(8'h03);
      #1 reset = 1'b0;
      #1;
      checkAllZero("midreset");
      #2 reset = 1'b1;
      applyStimulus(8'h02, 8'h02, 8'h20, 1'b0, 0, 1'b0, 8'h00);

`ifdef RX_TIMEOUT_EN
      $display("[TB] inter-byte timeout");
      sendByte(8'h05);
      k = 0;
      while (!(error1 && error4) && k < 40) begin
         tick();
         k++;
      end
      checkOutput("timeout_delay", k, TIMEOUT);
      checkOutput("timeout_busy", busy1, 0);
      checkOutput("timeout_keep_a", dato_a1, 8'h05);
      tick();
      checkOutput("error_width", error1, 0);
      applyStimulus(8'h09, 8'h04, 8'h22, 1'b0, 0, 1'b0, 8'h00);
`else
      $display("[TB] long silence without timeout");
      sendByte(8'h05);
      errs = 0;
      repeat (40) begin
         tick();
         errs += int'(error1) + int'(error4);
      end
      checkOutput("no_error", errs, 0);
      checkOutput("silence_busy", busy1, 0);
      applyStimulus(8'h05, 8'h0A, 8'h20, 1'b1, 0, 1'b0, 8'h00);
`endif

      $display("[TB] randomized frames");
      pending = 1'b0;
      na = '0;
      for (int f = 0; f < 16; f++) begin
         a  = pending ? na : DATA_W'($urandom);
         b  = DATA_W'($urandom);
         op = ops[$urandom_range(0, 5)];
         chain = (f < 15) && ($urandom_range(0, 1) == 1);
         na = DATA_W'($urandom);
         applyStimulus(a, b, op, pending, $urandom_range(0, 2), chain, na);
         pending = chain;
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
